// File: rtl/clint_access_arbiter_pkg.sv
// Shared types and register offsets for the CLINT access arbiter.
package clint_pkg;

  localparam int          CLINT_AW      = 16;
  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hbff8;

  typedef struct packed {
    logic                we;
    logic [CLINT_AW-1:0] addr;
    logic [63:0]         wdata;
  } clint_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/clint_access_arbiter_if.sv
// Requester-side and CLINT-side signal bundle of the access arbiter.
interface clint_access_arbiter_if #(
  parameter int NR_REQ     = 2,
  parameter int ADDR_WIDTH = 16
);
  logic [NR_REQ-1:0]                 acct_ctrl_i;
  logic [NR_REQ-1:0]                 req_i;
  logic [NR_REQ-1:0]                 we_i;
  logic [NR_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NR_REQ-1:0][63:0]           wdata_i;
  logic [NR_REQ-1:0]                 gnt_o;
  logic [NR_REQ-1:0]                 rvalid_o;
  logic [63:0]                       rdata_o;
  logic                              err_o;
  logic                              clint_en_o;
  logic                              clint_we_o;
  logic [ADDR_WIDTH-1:0]             clint_addr_o;
  logic [63:0]                       clint_wdata_o;
  logic [63:0]                       clint_rdata_i;

  modport slave (
    input  acct_ctrl_i, req_i, we_i, addr_i, wdata_i, clint_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
           clint_en_o, clint_we_o, clint_addr_o, clint_wdata_o
  );

  modport master (
    output acct_ctrl_i, req_i, we_i, addr_i, wdata_i, clint_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
           clint_en_o, clint_we_o, clint_addr_o, clint_wdata_o
  );
endinterface

// File: rtl/clint_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module clint_rr_arbiter #(
  parameter int NR_REQ = 2,
  localparam int IDXW  = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  output logic [NR_REQ-1:0] gnt,
  output logic [IDXW-1:0]   idx
);
  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < NR_REQ; off++) begin
      k = (int'(ptr) + off) % NR_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDXW'(k);
      end
    end
  end
endmodule

// File: rtl/clint_access_arbiter.sv
// Round-robin, access-controlled sharing of the CLINT register port; one
// transaction in flight with grant/access/response on consecutive cycles.
module clint_access_arbiter
  import clint_pkg::*;
#(
  parameter int                NR_REQ        = 2,
  parameter int                ADDR_WIDTH    = 16,
  parameter logic [NR_REQ-1:0] MTIME_WR_MASK = NR_REQ'(1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  clint_access_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NR_REQ);

  arb_state_e        state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, sel_q, pick_idx, ptr_nxt;
  logic [NR_REQ-1:0] pick_gnt, rvalid_q;
  logic              deny_q, deny_d, clint_en_q, err_q;
  clint_req_t        cmd_d, clint_q;
  logic [63:0]       rdata_q;

  clint_rr_arbiter #(.NR_REQ(NR_REQ)) u_rr (
    .req (bus.req_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    cmd_d.we    = bus.we_i[pick_idx];
    cmd_d.addr  = CLINT_AW'(bus.addr_i[pick_idx]);
    cmd_d.wdata = bus.wdata_i[pick_idx];
    deny_d      = !bus.acct_ctrl_i[pick_idx] |
                  (cmd_d.we & (cmd_d.addr == MTIME_BASE) & !MTIME_WR_MASK[pick_idx]);
    ptr_nxt     = (pick_idx == IDXW'(NR_REQ-1)) ? '0 : pick_idx + IDXW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req_i) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Downstream command is loaded on the grant edge so the CLINT sees registered,
  // glitch-free signals that are zero outside ACCESS or when the access is denied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      deny_q     <= 1'b0;
      clint_en_q <= 1'b0;
      clint_q    <= '0;
      rvalid_q   <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (|bus.req_i) begin
          sel_q      <= pick_idx;
          deny_q     <= deny_d;
          rr_ptr_q   <= ptr_nxt;
          clint_en_q <= !deny_d;
          clint_q    <= deny_d ? '0 : cmd_d;
        end
        ACCESS: begin
          clint_en_q <= 1'b0;
          clint_q    <= '0;
          rvalid_q   <= NR_REQ'(1) << sel_q;
          err_q      <= deny_q;
          rdata_q    <= (!deny_q && !clint_q.we) ? bus.clint_rdata_i : '0;
        end
        RESP: begin
          rvalid_q <= '0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt_o         = (state_q == IDLE) ? pick_gnt : '0;
  assign bus.rvalid_o      = rvalid_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.err_o         = err_q;
  assign bus.clint_en_o    = clint_en_q;
  assign bus.clint_we_o    = clint_q.we;
  assign bus.clint_addr_o  = ADDR_WIDTH'(clint_q.addr);
  assign bus.clint_wdata_o = clint_q.wdata;

endmodule

// File: tb/tb_clint_access_arbiter.sv
// Directed bench: 2-requester instance for function/protection/reset, 4-requester for fairness.
module tb_clint_access_arbiter;
  logic clk;
  logic rst_n;
  int   vec;
  int   errs;

  clint_access_arbiter_if #(.NR_REQ(2), .ADDR_WIDTH(16)) bus2 ();
  clint_access_arbiter_if #(.NR_REQ(4), .ADDR_WIDTH(16)) bus4 ();

  clint_access_arbiter #(.NR_REQ(2), .ADDR_WIDTH(16), .MTIME_WR_MASK(2'b01)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2.slave)
  );

  clint_access_arbiter #(.NR_REQ(4), .ADDR_WIDTH(16), .MTIME_WR_MASK(4'b0001)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  initial begin
    vec = 0; errs = 0;
    clk = 1'b0; rst_n = 1'b0;
    bus2.acct_ctrl_i = 2'b11; bus2.req_i = '0; bus2.we_i = '0;
    bus2.addr_i = '0; bus2.wdata_i = '0; bus2.clint_rdata_i = '0;
    bus4.acct_ctrl_i = 4'b1111; bus4.req_i = '0; bus4.we_i = '0;
    bus4.addr_i = '0; bus4.wdata_i = '0; bus4.clint_rdata_i = '0;

    #2;
    chk("rst_gnt",    bus2.gnt_o, 0);
    chk("rst_rvalid", bus2.rvalid_o, 0);
    chk("rst_err",    bus2.err_o, 0);
    chk("rst_rdata",  bus2.rdata_o, 0);
    chk("rst_en",     bus2.clint_en_o, 0);
    chk("rst_addr",   bus2.clint_addr_o, 0);
    half(); rst_n = 1'b1;
    tick();

    // single read of MTIME by requester 0
    bus2.req_i = 2'b01; bus2.we_i = 2'b00; bus2.addr_i[0] = 16'hbff8;
    bus2.clint_rdata_i = 64'h1234;
    half(); chk("rd_gnt", bus2.gnt_o, 2'b01);
    tick(); bus2.req_i = 2'b00;
    half(); chk("rd_en", bus2.clint_en_o, 1); chk("rd_we", bus2.clint_we_o, 0);
    chk("rd_addr", bus2.clint_addr_o, 16'hbff8); chk("rd_nogrant", bus2.gnt_o, 0);
    tick();
    half(); chk("rd_rvalid", bus2.rvalid_o, 2'b01); chk("rd_rdata", bus2.rdata_o, 64'h1234);
    chk("rd_err", bus2.err_o, 0); chk("rd_en_off", bus2.clint_en_o, 0);
    tick();

    // brief reset so rr_ptr starts from 0 for the contention case
    rst_n = 1'b0; #1; rst_n = 1'b1;
    bus2.addr_i[0] = 16'h0000; bus2.addr_i[1] = 16'h0000;
    bus2.req_i = 2'b11;
    half(); chk("ct_gnt0", bus2.gnt_o, 2'b01);
    tick();
    half(); chk("ct_gnt_acc", bus2.gnt_o, 0);
    tick();
    half(); chk("ct_rv0", bus2.rvalid_o, 2'b01);
    tick();
    half(); chk("ct_gnt3", bus2.gnt_o, 2'b10);
    tick(); bus2.req_i = 2'b01;
    tick();
    tick();
    half(); chk("ct_gnt6", bus2.gnt_o, 2'b01);
    tick(); bus2.req_i = 2'b00;
    tick();
    tick();

    // denied write: requester 1 disabled; enable flips after grant but must not matter
    bus2.acct_ctrl_i = 2'b01; bus2.we_i = 2'b10;
    bus2.addr_i[1] = 16'h4000; bus2.wdata_i[1] = 64'h55; bus2.req_i = 2'b10;
    half(); chk("dn_gnt", bus2.gnt_o, 2'b10);
    tick(); bus2.req_i = 2'b00; bus2.acct_ctrl_i = 2'b11;
    half(); chk("dn_en", bus2.clint_en_o, 0); chk("dn_we", bus2.clint_we_o, 0);
    chk("dn_addr", bus2.clint_addr_o, 0); chk("dn_wdata", bus2.clint_wdata_o, 0);
    tick();
    half(); chk("dn_rvalid", bus2.rvalid_o, 2'b10); chk("dn_err", bus2.err_o, 1);
    chk("dn_rdata", bus2.rdata_o, 0);
    tick();

    // MTIME write protection: requester 1 blocked, requester 0 allowed
    bus2.addr_i[1] = 16'hbff8; bus2.wdata_i[1] = 64'haa; bus2.we_i = 2'b10;
    bus2.req_i = 2'b10;
    half(); chk("mt1_gnt", bus2.gnt_o, 2'b10);
    tick(); bus2.req_i = 2'b00;
    half(); chk("mt1_en", bus2.clint_en_o, 0);
    tick();
    half(); chk("mt1_rvalid", bus2.rvalid_o, 2'b10); chk("mt1_err", bus2.err_o, 1);
    tick();
    bus2.we_i = 2'b01; bus2.addr_i[0] = 16'hbff8; bus2.wdata_i[0] = 64'h77;
    bus2.req_i = 2'b01;
    half(); chk("mt0_gnt", bus2.gnt_o, 2'b01);
    tick(); bus2.req_i = 2'b00;
    half(); chk("mt0_en", bus2.clint_en_o, 1); chk("mt0_we", bus2.clint_we_o, 1);
    chk("mt0_addr", bus2.clint_addr_o, 16'hbff8); chk("mt0_wdata", bus2.clint_wdata_o, 64'h77);
    tick();
    half(); chk("mt0_rvalid", bus2.rvalid_o, 2'b01); chk("mt0_err", bus2.err_o, 0);
    chk("mt0_rdata", bus2.rdata_o, 0);
    tick();

    // reset while the CLINT access is in progress
    bus2.we_i = 2'b00; bus2.addr_i[0] = 16'h4000; bus2.req_i = 2'b01;
    half(); chk("ra_gnt", bus2.gnt_o, 2'b01);
    tick(); bus2.req_i = 2'b00;
    half(); chk("ra_en", bus2.clint_en_o, 1);
    rst_n = 1'b0; #1;
    chk("ra_en_rst", bus2.clint_en_o, 0); chk("ra_addr_rst", bus2.clint_addr_o, 0);
    tick();
    half(); chk("ra_no_rvalid", bus2.rvalid_o, 0); chk("ra_err", bus2.err_o, 0);
    rst_n = 1'b1; bus2.req_i = 2'b11; #1;
    chk("ra_ptr0", bus2.gnt_o, 2'b01);
    tick(); bus2.req_i = 2'b00;
    tick();
    tick();

    // fairness with four requesters held high
    bus4.req_i = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      half(); chk("fr_gnt", bus4.gnt_o, 4'b0001 << (t % 4));
      tick();
      half(); chk("fr_idle_gnt", bus4.gnt_o, 0);
      tick();
      half(); chk("fr_rvalid", bus4.rvalid_o, 4'b0001 << (t % 4));
      tick();
    end
    bus4.req_i = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
